// File: rtl/bus_arbiter88.sv
// bus_arbiter88: single-port memory arbiter between the 8088-class core and
// one DMA requester. DMA bursts are capped at BURST_MAX transfers, and the
// core is guaranteed at least max(CPU_SLOT,1) advance cycles between grants.
module bus_arbiter88 #(
  parameter int BURST_MAX = 16,
  parameter int CPU_SLOT  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wreq,
  output logic        cpu_locked,
  input  logic        dma_req,
  input  logic [19:0] dma_address,
  input  logic [7:0]  dma_data,
  input  logic        dma_wreq,
  output logic        dma_grant,
  output logic [7:0]  dma_rdata,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_wreq,
  input  logic [7:0]  mem_in
);

  localparam logic [0:0] S_CPU = 1'b0;
  localparam logic [0:0] S_DMA = 1'b1;

  logic [0:0] owner;
  logic [7:0] slot_cnt;
  logic [7:0] burst_cnt;
  logic [7:0] slot_nxt;
  logic       dma_sel;
  logic       burst_last;

  // Slot counter after this edge's decrement; the re-grant test looks at this
  // value so a full CPU_SLOT of locked cycles elapses before the grant cycle.
  always_comb begin
    slot_nxt = slot_cnt;
    if (pll_locked && (slot_cnt != 8'd0))
      slot_nxt = slot_cnt - 8'd1;
  end

  // Reset hands the port to the core immediately, even mid-burst.
  assign dma_sel    = (owner == S_DMA) && !reset;
  assign burst_last = (burst_cnt == 8'(BURST_MAX - 1));

  // Memory port mux; the non-owner's write strobe never reaches memory.
  always_comb begin
    mem_address = cpu_address;
    mem_out     = cpu_data;
    mem_wreq    = cpu_wreq && !reset;
    if (dma_sel) begin
      mem_address = dma_address;
      mem_out     = dma_data;
      mem_wreq    = dma_wreq;
    end
  end

  assign cpu_locked = (owner == S_CPU) && pll_locked && !reset;
  assign dma_grant  = dma_sel;
  assign dma_rdata  = mem_in;

  // Ownership FSM with CPU-slot and DMA-burst counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner     <= S_CPU;
      slot_cnt  <= 8'(CPU_SLOT);
      burst_cnt <= 8'd0;
    end else if (owner == S_CPU) begin
      slot_cnt <= slot_nxt;
      if (dma_req && (slot_nxt == 8'd0)) begin
        owner     <= S_DMA;
        burst_cnt <= 8'd0;
      end
    end else begin
      // Every edge with dma_req high is one completed transfer.
      if (dma_req)
        burst_cnt <= burst_cnt + 8'd1;
      // Idle request or the final transfer of a capped burst: one exit.
      if (!dma_req || burst_last) begin
        owner    <= S_CPU;
        slot_cnt <= 8'(CPU_SLOT);
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter88.sv
// Directed bench for bus_arbiter88 (BURST_MAX=16, CPU_SLOT=4) with a small
// behavioural memory on the arbitrated port.
module tb_bus_arbiter88;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pll_locked = 1'b1;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_wreq = 1'b0;
  logic        cpu_locked;
  logic        dma_req = 1'b0;
  logic [19:0] dma_address = '0;
  logic [7:0]  dma_data = '0;
  logic        dma_wreq = 1'b0;
  logic        dma_grant;
  logic [7:0]  dma_rdata;
  logic [19:0] mem_address;
  logic [7:0]  mem_out;
  logic        mem_wreq;
  logic [7:0]  mem_in;

  int checks = 0;
  int errors = 0;

  bus_arbiter88 #(.BURST_MAX(16), .CPU_SLOT(4)) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wreq(cpu_wreq),
    .cpu_locked(cpu_locked), .dma_req(dma_req), .dma_address(dma_address),
    .dma_data(dma_data), .dma_wreq(dma_wreq), .dma_grant(dma_grant),
    .dma_rdata(dma_rdata), .mem_address(mem_address), .mem_out(mem_out),
    .mem_wreq(mem_wreq), .mem_in(mem_in)
  );

  always #5 clock = ~clock;

  // Memory model: sparse address folding, unwritten bytes read 0xEE.
  logic [7:0]  mem [0:32767];
  logic        clr = 1'b1;
  logic        pl_we = 1'b0;
  logic [19:0] pl_a = '0;
  logic [7:0]  pl_d = '0;
  int          wr_400 = 0;

  function automatic logic [14:0] ix(input logic [19:0] a);
    return {a[19:16], a[10:0]};
  endfunction

  assign mem_in = mem[ix(mem_address)];

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 8'hEE;
    end else if (pl_we) begin
      mem[ix(pl_a)] <= pl_d;
    end else if (mem_wreq) begin
      mem[ix(mem_address)] <= mem_out;
      if (mem_address == 20'h00400) wr_400 <= wr_400 + 1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic preload(input logic [19:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    cyc();
    pl_we = 1'b0;
  endtask

  // Two reset cycles with idle inputs; returns in the first cycle after release.
  task automatic do_reset(input logic pll);
    reset = 1'b1; dma_req = 1'b0; dma_wreq = 1'b0; cpu_wreq = 1'b0;
    pll_locked = pll;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b1; dma_req = 1'b1; dma_wreq = 1'b1;
    dma_address = 20'hB8100; dma_data = 8'h77;
    cpu_wreq = 1'b1; cpu_address = 20'h12345;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (cpu_locked !== 1'b0) begin errors++; $display("FAIL rst_cpu_locked i=%0d got %b want 0", i, cpu_locked); end
      checks++; if (dma_grant !== 1'b0) begin errors++; $display("FAIL rst_grant i=%0d got %b want 0", i, dma_grant); end
      checks++; if (mem_wreq !== 1'b0) begin errors++; $display("FAIL rst_wreq i=%0d got %b want 0", i, mem_wreq); end
      checks++; if (mem_address !== 20'h12345) begin errors++; $display("FAIL rst_addr i=%0d got %h want 12345", i, mem_address); end
      cyc();
    end
    reset = 1'b0; dma_wreq = 1'b0; cpu_wreq = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 4) begin
        checks++; if (cpu_locked !== 1'b1) begin errors++; $display("FAIL rel_cpu_locked c=%0d got %b want 1", c, cpu_locked); end
        checks++; if (dma_grant !== 1'b0) begin errors++; $display("FAIL rel_grant c=%0d got %b want 0", c, dma_grant); end
      end else if (c == 4) begin
        checks++; if (dma_grant !== 1'b1) begin errors++; $display("FAIL rel_grant c=4 got %b want 1", dma_grant); end
        checks++; if (cpu_locked !== 1'b0) begin errors++; $display("FAIL rel_stall c=4 got %b want 0", cpu_locked); end
        dma_req = 1'b0;
      end else begin
        checks++; if (cpu_locked !== 1'b1) begin errors++; $display("FAIL rel_back c=5 got %b want 1", cpu_locked); end
      end
      cyc();
    end
  endtask

  task automatic test_burst_cap();
    int n;
    logic exp;
    do_reset(1'b1);
    dma_wreq = 1'b1;
    n = 0;
    for (int c = 0; c < 42; c++) begin
      dma_req = (n < 32);
      dma_address = 20'hB8000 + n[19:0];
      dma_data = n[7:0];
      #1;
      exp = (c >= 4 && c < 20) || (c >= 24 && c < 40);
      checks++; if (dma_grant !== exp) begin errors++; $display("FAIL burst_grant c=%0d got %b want %b", c, dma_grant, exp); end
      checks++; if (cpu_locked !== !exp) begin errors++; $display("FAIL burst_cpu_locked c=%0d got %b want %b", c, cpu_locked, !exp); end
      if (c == 20) begin
        checks++; if (mem[ix(20'hB800F)] !== 8'h0F) begin errors++; $display("FAIL burst_16th got %h want 0f", mem[ix(20'hB800F)]); end
        checks++; if (mem[ix(20'hB8010)] !== 8'hEE) begin errors++; $display("FAIL burst_17th_early got %h want ee", mem[ix(20'hB8010)]); end
      end
      if (dma_grant && dma_req) n++;
      cyc();
    end
    dma_req = 1'b0; dma_wreq = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL burst_count got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[ix(20'hB8000 + 20'(i))] !== 8'(i)) begin
        errors++; $display("FAIL burst_data i=%0d got %h want %h", i, mem[ix(20'hB8000 + 20'(i))], 8'(i));
      end
    end
  endtask

  task automatic test_early_release();
    int xfers;
    logic [7:0] exp;
    preload(20'hA0000, 8'h12);
    preload(20'hA0001, 8'h34);
    preload(20'hA0002, 8'h56);
    do_reset(1'b1);
    dma_wreq = 1'b0;
    xfers = 0;
    for (int c = 0; c < 9; c++) begin
      dma_req = (c < 7);
      dma_address = 20'hA0000 + ((c >= 4) ? 20'(c - 4) : 20'd0);
      #1;
      if (c >= 4 && c <= 6) begin
        exp = (c == 4) ? 8'h12 : (c == 5) ? 8'h34 : 8'h56;
        checks++; if (dma_grant !== 1'b1) begin errors++; $display("FAIL early_grant c=%0d got %b want 1", c, dma_grant); end
        checks++; if (dma_rdata !== exp) begin errors++; $display("FAIL early_rdata c=%0d got %h want %h", c, dma_rdata, exp); end
      end
      if (c == 7) begin
        checks++; if (dma_grant !== 1'b1) begin errors++; $display("FAIL early_hold c=7 got %b want 1", dma_grant); end
      end
      if (c == 8) begin
        checks++; if (cpu_locked !== 1'b1) begin errors++; $display("FAIL early_cpu_back got %b want 1", cpu_locked); end
        checks++; if (dma_grant !== 1'b0) begin errors++; $display("FAIL early_grant_drop got %b want 0", dma_grant); end
      end
      if (dma_grant && dma_req) xfers++;
      cyc();
    end
    checks++; if (xfers != 3) begin errors++; $display("FAIL early_xfers got %0d want 3", xfers); end
  endtask

  task automatic test_write_mask();
    int w0;
    preload(20'h00400, 8'h5A);
    do_reset(1'b1);
    w0 = wr_400;
    dma_wreq = 1'b0; dma_address = 20'h00400;
    cpu_address = 20'h00400; cpu_data = 8'hAA;
    for (int c = 0; c < 10; c++) begin
      dma_req = (c < 7);
      cpu_wreq = (c >= 4 && c < 9);
      #1;
      if (c >= 4 && c <= 7) begin
        checks++; if (mem_wreq !== 1'b0) begin errors++; $display("FAIL mask_wreq c=%0d got %b want 0", c, mem_wreq); end
      end
      if (c >= 4 && c <= 6) begin
        checks++; if (dma_rdata !== 8'h5A) begin errors++; $display("FAIL mask_rdata c=%0d got %h want 5a", c, dma_rdata); end
      end
      if (c == 8) begin
        checks++; if (mem_wreq !== 1'b1) begin errors++; $display("FAIL mask_cpu_wreq got %b want 1", mem_wreq); end
        checks++; if (mem_out !== 8'hAA) begin errors++; $display("FAIL mask_cpu_data got %h want aa", mem_out); end
      end
      cyc();
    end
    cpu_wreq = 1'b0;
    checks++; if (mem[ix(20'h00400)] !== 8'hAA) begin errors++; $display("FAIL mask_final got %h want aa", mem[ix(20'h00400)]); end
    checks++; if (wr_400 - w0 != 1) begin errors++; $display("FAIL mask_once got %0d want 1", wr_400 - w0); end
  endtask

  task automatic test_pll();
    logic eg, ec;
    do_reset(1'b0);
    dma_wreq = 1'b0; dma_address = 20'h00010;
    for (int c = 0; c < 16; c++) begin
      pll_locked = (c >= 10);
      dma_req = (c < 14);
      #1;
      eg = (c == 14);
      ec = (c >= 10 && c < 14) || (c == 15);
      checks++; if (dma_grant !== eg) begin errors++; $display("FAIL pll_grant c=%0d got %b want %b", c, dma_grant, eg); end
      checks++; if (cpu_locked !== ec) begin errors++; $display("FAIL pll_cpu_locked c=%0d got %b want %b", c, cpu_locked, ec); end
      cyc();
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset(1'b1);
    dma_wreq = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      dma_address = 20'hC0000 + n[19:0];
      dma_data = 8'h80 + n[7:0];
      reset = (c == 8);
      dma_req = (c < 9);
      #1;
      if (c == 8) begin
        checks++; if (dma_grant !== 1'b0) begin errors++; $display("FAIL mid_grant got %b want 0", dma_grant); end
        checks++; if (mem_wreq !== 1'b0) begin errors++; $display("FAIL mid_wreq got %b want 0", mem_wreq); end
        checks++; if (cpu_locked !== 1'b0) begin errors++; $display("FAIL mid_cpu_locked got %b want 0", cpu_locked); end
      end
      if (c == 9) begin
        checks++; if (cpu_locked !== 1'b1) begin errors++; $display("FAIL mid_cpu_owner got %b want 1", cpu_locked); end
        checks++; if (dma_grant !== 1'b0) begin errors++; $display("FAIL mid_after_grant got %b want 0", dma_grant); end
      end
      if (dma_grant && dma_req) n++;
      cyc();
    end
    dma_wreq = 1'b0;
    checks++; if (mem[ix(20'hC0003)] !== 8'h83) begin errors++; $display("FAIL mid_4th got %h want 83", mem[ix(20'hC0003)]); end
    checks++; if (mem[ix(20'hC0004)] !== 8'hEE) begin errors++; $display("FAIL mid_5th got %h want ee", mem[ix(20'hC0004)]); end
  endtask

  initial begin
    cyc();
    clr = 1'b0;
    test_reset();
    test_burst_cap();
    test_early_release();
    test_write_mask();
    test_pll();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter88.md
# bus_arbiter88

Single-port memory arbiter and scheduler between the 8088-class core and one DMA requester (video refresh / block transfer engine). It owns the 20-bit address / 8-bit data memory port and drives the core's `locked` (advance-enable) input, stalling the core whenever the DMA side holds the bus. It enforces bounded DMA bursts and a guaranteed minimum CPU slot, so neither side starves.

## Interface

Parameters:
- `BURST_MAX`, 16: maximum DMA transfers per grant (1..255).
- `CPU_SLOT`, 4: minimum CPU-advance cycles between DMA grants (0..255).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pll_locked` in 1: clock-good qualifier; the core may advance only when this is 1.
- `cpu_address` in 20: core address, {seg,4'h0}+offset already summed.
- `cpu_data` in 8: core write data.
- `cpu_wreq` in 1: core write request.
- `cpu_locked` out 1: to core `locked`; core executes a step on each edge where this is 1.
- `dma_req` in 1: DMA wants the bus; held high for every cycle a transfer is wanted.
- `dma_address` in 20: DMA address.
- `dma_data` in 8: DMA write data.
- `dma_wreq` in 1: DMA write (1) / read (0).
- `dma_grant` out 1: DMA owns the bus this cycle.
- `dma_rdata` out 8: read data; equals `mem_in`, valid in grant cycles.
- `mem_address` out 20: memory address.
- `mem_out` out 8: memory write data.
- `mem_wreq` out 1: memory write strobe, committed on the rising edge.
- `mem_in` in 8: memory read data, combinational from `mem_address` in the same cycle.

## Operation

- State register `owner` ∈ {S_CPU, S_DMA}, plus 8-bit `slot_cnt` and 8-bit `burst_cnt`.
- Mux, combinational from the registered `owner`:
  - S_CPU: `mem_address`/`mem_out`/`mem_wreq` = cpu_*.
  - S_DMA: the same signals = dma_*.
  - `mem_wreq` = 0 whenever `reset`=1.
- `cpu_locked` = (`owner`==S_CPU) & `pll_locked` & !`reset`.
- `dma_grant` = (`owner`==S_DMA) & !`reset`.
- The non-owner's `wreq` is always masked. A core write pending while stalled reaches memory only after the CPU regains the bus.
- S_CPU:
  - `slot_cnt` decrements, saturating at 0, on each edge where `pll_locked`=1.
  - If `dma_req` & (`slot_cnt`==0) at the edge: go to S_DMA, `burst_cnt`←0.
- S_DMA:
  - Each edge with `dma_req`=1 is one completed transfer: write commits, or read data is sampled from `dma_rdata` by the requester. `burst_cnt` increments.
  - Go to S_CPU and load `slot_cnt`←CPU_SLOT when either:
    - `dma_req`=0, with no transfer that cycle; or
    - `burst_cnt`==BURST_MAX-1 and a transfer occurs, i.e. the BURST_MAX-th transfer.
- If both exit conditions are true in the same cycle, there is exactly one exit and one `slot_cnt` load.
- With CPU_SLOT=0, back-to-back grants are allowed. There is still at least one S_CPU cycle between bursts, because the re-grant is evaluated from S_CPU.
- `pll_locked`=0 does not block DMA. It only freezes `slot_cnt` and holds `cpu_locked` low.

## Timing

- Reset, while `reset`=1 and after release:
  - `owner`=S_CPU, `slot_cnt`=CPU_SLOT, `burst_cnt`=0.
  - `cpu_locked`=0 and `dma_grant`=0 during reset; `mem_wreq`=0.
  - `mem_address`=`cpu_address` and `dma_rdata`=`mem_in` (pure muxes).
- Reset mid-burst: the grant drops in the same cycle `reset` is sampled high. The DMA write in that cycle is suppressed.
- Grant latency:
  - `dma_req` rising before edge k, in S_CPU with `slot_cnt`==0 → `dma_grant`=1 from cycle k+1.
  - The core stalls in that same cycle (`cpu_locked`=0); there is no overlap cycle.
- Release latency: the exit decision at edge k → `cpu_locked` returns in cycle k+1, given `pll_locked`=1.
- Throughput: one byte per cycle in S_DMA; no turnaround cycles.
- Starvation bound:
  - DMA holds the bus for at most BURST_MAX cycles.
  - The CPU then advances for at least max(CPU_SLOT,1) locked cycles before the next grant.

## Test plan

- Reset: hold `reset` 3 cycles with `dma_req`=1 → `cpu_locked`=0, `dma_grant`=0, `mem_wreq`=0. After release with `pll_locked`=1: `cpu_locked`=1 for exactly 4 cycles, then `dma_grant`=1.
- Burst cap: BURST_MAX=16, `dma_req` held high, DMA writes 0x00..0x1F to 0xB8000+ → exactly 16 writes (0x00..0x0F) land. Then the grant drops, `cpu_locked`=1 for 4 cycles, and the remaining 16 writes follow.
- Early release: `dma_req` high for 3 cycles reading 0x12,0x34,0x56 from memory → `dma_rdata` matches, 3 transfers. `cpu_locked` returns the cycle after `dma_req` falls.
- Write masking: the core asserts `cpu_wreq`=1 to 0x00400 at the edge the grant starts, with DMA reading 0x00400 → no write during the DMA burst. The core write commits once in the first S_CPU cycle after release.
- `pll_locked`=0 for 10 cycles after reset with `dma_req`=1 → no DMA grant (`slot_cnt` frozen at 4) and `cpu_locked`=0. The grant arrives 4 locked cycles after `pll_locked` rises.
- Reset mid-burst: assert `reset` on the 5th DMA write → that write is not committed, and the bus is owned by the CPU after release.
